data_mem_mmio: RTL and testbench

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

---
 rtl/data_mem_mmio.sv | 168 ++++++++++++++++
 tb/tb_data_mem_mmio.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word-addressed data RAM plus a small memory-mapped peripheral
// block (LED register, free-running cycle counter, timer compare with sticky
// interrupt, status flags) and a byte-wide console transmit FIFO.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] leds,
    output logic        irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES  = 32'(RAM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [31:0]   ADDR_LED   = 32'h0000_1000;
    localparam logic [31:0]   ADDR_CYCLE = 32'h0000_1004;
    localparam logic [31:0]   ADDR_TX    = 32'h0000_1008;
    localparam logic [31:0]   ADDR_TCMP  = 32'h0000_100C;
    localparam logic [31:0]   ADDR_STAT  = 32'h0000_1010;

    // Storage
    logic [31:0]   ram_r  [RAM_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [31:0]   led_r;
    logic [31:0]   cycle_r;
    logic [31:0]   tcmp_r;
    logic          irq_r;
    logic          ovf_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Decode and control
    logic [31:0]   word_addr_s;
    logic [AW-1:0] ram_idx_s;
    logic          sel_ram_s;
    logic          we_led_s;
    logic          we_tx_s;
    logic          we_tcmp_s;
    logic          we_stat_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic          push_acc_s;
    logic          ovf_set_s;
    logic          irq_set_s;
    logic [3:0]    count4_s;
    logic [31:0]   txstat_s;
    logic [31:0]   read_data_s;
    logic          unused_s;

    // Byte-offset bits play no part in word addressing.
    assign unused_s    = ^ALUResult[1:0];
    assign word_addr_s = {ALUResult[31:2], 2'b00};
    assign ram_idx_s   = ALUResult[AW+1:2];

    // Address decode, FIFO handshake and flag-set conditions.
    always_comb begin
        sel_ram_s    = (word_addr_s < RAM_BYTES);
        we_led_s     = MemWrite && (word_addr_s == ADDR_LED);
        we_tx_s      = MemWrite && (word_addr_s == ADDR_TX);
        we_tcmp_s    = MemWrite && (word_addr_s == ADDR_TCMP);
        we_stat_s    = MemWrite && (word_addr_s == ADDR_STAT);
        fifo_empty_s = (count_r == {CW{1'b0}});
        fifo_full_s  = (count_r == DEPTH_C);
        pop_s        = !fifo_empty_s && tx_ready;
        // A full FIFO still takes a byte if the head leaves at the same edge.
        push_acc_s   = we_tx_s && (!fifo_full_s || pop_s);
        ovf_set_s    = we_tx_s && fifo_full_s && !pop_s;
        irq_set_s    = (tcmp_r != 32'h0) && (cycle_r == tcmp_r);
        count4_s     = 4'(count_r);
        txstat_s     = {24'h0, count4_s, 2'b00, fifo_full_s, fifo_empty_s};
    end

    // Load data mux; RAM reads are asynchronous so a same-cycle store is not seen.
    always_comb begin
        read_data_s = 32'h0;
        if (sel_ram_s) begin
            read_data_s = ram_r[ram_idx_s];
        end else begin
            case (word_addr_s)
                ADDR_LED:   read_data_s = led_r;
                ADDR_CYCLE: read_data_s = cycle_r;
                ADDR_TX:    read_data_s = txstat_s;
                ADDR_TCMP:  read_data_s = tcmp_r;
                ADDR_STAT:  read_data_s = {30'h0, ovf_r, irq_r};
                default:    read_data_s = 32'h0;
            endcase
        end
    end

    // RAM store port; deliberately outside reset so stores complete during reset.
    always_ff @(posedge clk) begin
        if (MemWrite && sel_ram_s) begin
            ram_r[ram_idx_s] <= WriteData;
        end
    end

    // MMIO registers: LED, cycle counter, timer compare and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r   <= 32'h0;
            cycle_r <= 32'h0;
            tcmp_r  <= 32'h0;
            irq_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            cycle_r <= cycle_r + 32'h1;
            if (we_led_s) begin
                led_r <= WriteData;
            end
            if (we_tcmp_s) begin
                tcmp_r <= WriteData;
            end
            // Set has priority over a write-one-to-clear at the same edge.
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (we_stat_s && WriteData[0]) begin
                irq_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (we_stat_s && WriteData[1]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Console TX FIFO: circular buffer with head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_acc_s) begin
                fifo_r[tail_r] <= WriteData[7:0];
                tail_r         <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_acc_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign ReadData = read_data_s;
    assign leds     = led_r;
    assign irq      = irq_r;
    assign tx_valid = !fifo_empty_s;
    assign tx_data  = fifo_empty_s ? 8'h00 : fifo_r[head_r];

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: directed scenarios followed by random traffic, all
// checked against a queue/array reference model of the memory map.
module tb_data_mem_mmio;
    localparam int RW = 64;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] leds;
    logic        irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    data_mem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .leds(leds), .irq(irq),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [RW];
    bit          m_ram_ok [RW];
    logic [31:0] m_led, m_cycle, m_tcmp;
    bit          m_irq, m_ovf, m_known;
    logic [7:0]  m_q [$];
    logic [7:0]  popped [$];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        logic [31:0] r;
        int n;
        a = {addr[31:2], 2'b00};
        n = m_q.size();
        r = 32'h0;
        if (a < RW * 4) r = m_ram[a >> 2];
        else if (a == 32'h1000) r = m_led;
        else if (a == 32'h1004) r = m_cycle;
        else if (a == 32'h1008) begin
            r[0]   = (n == 0);
            r[1]   = (n == D);
            r[7:4] = 4'(n);
        end
        else if (a == 32'h100C) r = m_tcmp;
        else if (a == 32'h1010) r = {30'h0, m_ovf, m_irq};
        return r;
    endfunction

    // One clock cycle: drive, check the combinational load, advance model, check outputs.
    task automatic step(input bit rst, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input bit rdy);
        logic [31:0] a;
        int n;
        bit pop, push;
        reset = rst; MemWrite = we; ALUResult = addr; WriteData = data; tx_ready = rdy;
        #1;
        last_rd = ReadData;
        a = {addr[31:2], 2'b00};
        if (m_known && !(a < RW * 4 && !m_ram_ok[a >> 2]))
            check("rdata", ReadData, model_read(addr));
        if (m_known && !rst && tx_valid && rdy) popped.push_back(tx_data);
        @(posedge clk);
        if (we && a < RW * 4) begin
            m_ram[a >> 2]    = data;
            m_ram_ok[a >> 2] = 1'b1;
        end
        if (rst) begin
            m_led = 32'h0; m_cycle = 32'h0; m_tcmp = 32'h0;
            m_irq = 1'b0; m_ovf = 1'b0; m_q.delete(); m_known = 1'b1;
        end else begin
            n    = m_q.size();
            pop  = (n != 0) && rdy;
            push = we && (a == 32'h1008);
            if (m_tcmp != 32'h0 && m_cycle == m_tcmp) m_irq = 1'b1;
            else if (we && a == 32'h1010 && data[0]) m_irq = 1'b0;
            if (push && n == D && !pop) m_ovf = 1'b1;
            else if (we && a == 32'h1010 && data[1]) m_ovf = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (push && (n < D || pop)) m_q.push_back(data[7:0]);
            if (we && a == 32'h1000) m_led = data;
            if (we && a == 32'h100C) m_tcmp = data;
            m_cycle = m_cycle + 32'h1;
        end
        #1;
        if (m_known) begin
            check("leds", leds, m_led);
            check("irq", {31'h0, irq}, {31'h0, m_irq});
            check("tx_valid", {31'h0, tx_valid}, {31'h0, (m_q.size() != 0)});
            if (m_q.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
            else check("tx_data_idle", {24'h0, tx_data}, 32'h0);
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h1010, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] addr, data;
        int sel;
        reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; tx_ready = 1'b0;
        m_known = 1'b0;
        for (int i = 0; i < RW; i++) m_ram_ok[i] = 1'b0;
        @(posedge clk); #1;

        // Reset state and first cycle after reset
        step(1'b1, 1'b0, 32'h1004, 32'h0, 1'b0);
        check("rst_leds", leds, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        step(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
        check("cycle_first", last_rd, 32'h0);

        // RAM store/load, ignored byte offset, unmapped read
        step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("ram_10", last_rd, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
        check("ram_13", last_rd, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
        check("unmapped", last_rd, 32'h0);

        // Timer match at CYCLE 5->6, then W1C clear
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h100C, 32'd5, 1'b0);
        repeat (4) idle(1'b0);
        check("irq_before", {31'h0, irq}, 32'h0);
        idle(1'b0);
        check("irq_match", {31'h0, irq}, 32'h1);
        idle(1'b0);
        check("stat_irq", last_rd, 32'h1);
        step(1'b0, 1'b1, 32'h1010, 32'h1, 1'b0);
        check("irq_clr", {31'h0, irq}, 32'h0);
        repeat (6) idle(1'b0);
        check("irq_stays_clr", {31'h0, irq}, 32'h0);

        // Overflow: five pushes into a stalled FIFO
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        popped.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h1008, 32'h41 + 32'(i), 1'b0);
        step(1'b0, 1'b0, 32'h1008, 32'h0, 1'b0);
        check("txstat_full", last_rd, 32'h42);
        idle(1'b0);
        check("stat_ovf", last_rd, 32'h2);
        repeat (6) idle(1'b1);
        check("ovf_npop", popped.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("ovf_order", {24'h0, popped[i]}, 32'h41 + 32'(i));

        // Push into a full FIFO while popping
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        popped.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h1008, 32'h41 + 32'(i), 1'b0);
        step(1'b0, 1'b1, 32'h1008, 32'h55, 1'b1);
        step(1'b0, 1'b0, 32'h1008, 32'h0, 1'b0);
        check("full_pushpop", last_rd, 32'h42);
        repeat (6) idle(1'b1);
        check("fp_npop", popped.size(), 32'd5);
        check("fp_first", {24'h0, popped[0]}, 32'h41);
        check("fp_last", {24'h0, popped[4]}, 32'h55);
        idle(1'b0);
        check("fp_no_ovf", last_rd, 32'h0);

        // Single byte through an empty FIFO
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        popped.delete();
        step(1'b0, 1'b1, 32'h1008, 32'h7A, 1'b1);
        check("single_valid", {31'h0, tx_valid}, 32'h1);
        idle(1'b1);
        check("single_done", {31'h0, tx_valid}, 32'h0);
        check("single_npop", popped.size(), 32'd1);
        check("single_byte", {24'h0, popped[0]}, 32'h7A);

        // Reset mid-operation
        step(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
        step(1'b0, 1'b1, 32'h1000, 32'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h1008, 32'h30 + 32'(i), 1'b0);
        check("pre_rst_leds", leds, 32'hFF);
        step(1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 1'b0);
        check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_leds", leds, 32'h0);
        step(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
        check("mid_rst_cycle", last_rd, 32'h0);
        step(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        check("ram_kept", last_rd, 32'h12345678);
        step(1'b0, 1'b0, 32'h24, 32'h0, 1'b0);
        check("ram_in_rst", last_rd, 32'hCAFEF00D);
        step(1'b1, 1'b1, 32'h1000, 32'hAB, 1'b0);
        check("led_in_rst", leds, 32'h0);

        // Random traffic against the model
        repeat (500) begin
            sel  = int'($urandom_range(0, 7));
            data = $urandom;
            case (sel)
                0, 1: addr = 32'($urandom_range(0, RW - 1)) * 32'd4 + 32'($urandom_range(0, 3));
                2: addr = 32'h1000;
                3: addr = 32'h1004;
                4: addr = 32'h1008;
                5: begin
                    addr = 32'h100C;
                    data = m_cycle + 32'($urandom_range(1, 10));
                end
                6: begin
                    addr = 32'h1010;
                    data = 32'($urandom_range(0, 3));
                end
                default: addr = $urandom;
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, addr, data,
                 $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
